player_ctrl: RTL and testbench



---
 rtl/player_pkg.sv | 48 ++++
 rtl/player_if.sv | 33 +++
 rtl/player_ctrl_btn_edge.sv | 25 ++
 rtl/player_ctrl.sv | 146 ++++++++++++++
 tb/tb_player_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/player_pkg.sv
// Grid geometry, level encoding and FSM state shared by the player controller and the renderer.
package player_pkg;

   localparam int ROW      = 40;
   localparam int MAP_BITS = 1200;

   localparam int COLS_EZ = 16;
   localparam int ROWS_EZ = 12;
   localparam int COLS_MI = 32;
   localparam int ROWS_MI = 24;
   localparam int COLS_HD = 40;
   localparam int ROWS_HD = 30;

   localparam int PIX_EZ = 40;
   localparam int PIX_MI = 20;
   localparam int PIX_HD = 16;

   typedef enum logic [1:0] {
      LVL_NONE = 2'b00,
      LVL_EZ   = 2'b01,
      LVL_MI   = 2'b10,
      LVL_HD   = 2'b11
   } level_t;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CHECK, ST_GOAL} state_t;

   // An invalid level reports a 0x0 grid, so every target is out of bounds.
   function automatic logic [6:0] level_cols(input level_t lvl);
      case (lvl)
         LVL_EZ:  return 7'(COLS_EZ);
         LVL_MI:  return 7'(COLS_MI);
         LVL_HD:  return 7'(COLS_HD);
         default: return 7'd0;
      endcase
   endfunction

   function automatic logic [5:0] level_rows(input level_t lvl);
      case (lvl)
         LVL_EZ:  return 6'(ROWS_EZ);
         LVL_MI:  return 6'(ROWS_MI);
         LVL_HD:  return 6'(ROWS_HD);
         default: return 6'd0;
      endcase
   endfunction

endpackage

// File: rtl/player_if.sv
// Signal bundle between the game front end (master) and the player controller (slave).
interface player_if #(parameter int CNT_W = 10);
   import player_pkg::*;

   // No valid/ready pairs: draw_done and start are single-cycle strobes that are always
   // accepted on the cycle they are high; btn is a raw asynchronous level.
   logic [1:0]          level;
   logic [MAP_BITS-1:0] map;
   logic [3:0]          btn;
   logic                draw_done;
   logic                start;
   logic [5:0]          start_x;
   logic [4:0]          start_y;
   logic [5:0]          goal_x;
   logic [4:0]          goal_y;
   logic [5:0]          pos_x;
   logic [4:0]          pos_y;
   logic                goal;
   logic                bump;
   logic [CNT_W-1:0]    move_cnt;
   state_t              state;

   modport master (
      output level, map, btn, draw_done, start, start_x, start_y, goal_x, goal_y,
      input  pos_x, pos_y, goal, bump, move_cnt, state
   );

   modport slave (
      input  level, map, btn, draw_done, start, start_x, start_y, goal_x, goal_y,
      output pos_x, pos_y, goal, bump, move_cnt, state
   );

endinterface

// File: rtl/player_ctrl_btn_edge.sv
// Two-flop synchronizer for the four buttons followed by a per-button rising-edge detect.
module btn_edge (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   output logic [3:0] rise
);

   logic [3:0] sync1, sync2, prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 4'b0;
         sync2 <= 4'b0;
         prev  <= 4'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;

endmodule

// File: rtl/player_ctrl.sv
// Player position controller: buffers one button request and applies it, bounds- and
// wall-checked, only on the renderer's end-of-frame strobe.
module player_ctrl #(
   parameter int ROW   = player_pkg::ROW,
   parameter int CNT_W = 10
) (
   input logic     clk,
   input logic     rst,
   player_if.slave bus
);
   import player_pkg::*;

   state_t           state, state_nx;
   logic [3:0]       rise;
   logic             rise_any;
   dir_t             rise_dir;
   logic             pend_vld;
   dir_t             pend_dir;
   logic [5:0]       pos_x;
   logic [4:0]       pos_y;
   logic [6:0]       step_x, tgt_x;
   logic [5:0]       step_y, tgt_y;
   logic [6:0]       cols;
   logic [5:0]       rows;
   logic             in_bounds;
   logic [10:0]      cell_idx, bit_idx;
   logic             legal;
   logic [5:0]       res_x;
   logic [4:0]       res_y;
   logic             bump;
   logic [CNT_W-1:0] cnt;

   btn_edge u_btn_edge (
      .clk  (clk),
      .rst  (rst),
      .btn  (bus.btn),
      .rise (rise)
   );

   assign rise_any = |rise;

   always_comb begin
      rise_dir = DIR_RIGHT;
      if (rise[3])      rise_dir = DIR_UP;
      else if (rise[2]) rise_dir = DIR_DOWN;
      else if (rise[1]) rise_dir = DIR_LEFT;
   end

   // One extra bit lets a step below 0 wrap to a large value that fails the bounds test.
   always_comb begin
      step_x = {1'b0, pos_x};
      step_y = {1'b0, pos_y};
      case (pend_dir)
         DIR_UP:    step_y = step_y - 6'd1;
         DIR_DOWN:  step_y = step_y + 6'd1;
         DIR_LEFT:  step_x = step_x - 7'd1;
         DIR_RIGHT: step_x = step_x + 7'd1;
         default:   ;
      endcase
   end

   always_comb begin
      cols      = level_cols(level_t'(bus.level));
      rows      = level_rows(level_t'(bus.level));
      in_bounds = (bus.level != LVL_NONE) && (tgt_x < cols) && (tgt_y < rows);
      cell_idx  = 11'(tgt_y) * 11'(ROW) + 11'(tgt_x);
      bit_idx   = in_bounds ? 11'(MAP_BITS - 1) - cell_idx : 11'd0;
      legal     = in_bounds && !bus.map[bit_idx];
      res_x     = legal ? tgt_x[5:0] : pos_x;
      res_y     = legal ? tgt_y[4:0] : pos_y;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.start) begin
         state_nx = ST_ARMED;
      end else begin
         case (state)
            ST_ARMED: if (bus.draw_done && pend_vld) state_nx = ST_CHECK;
            ST_CHECK: state_nx = (res_x == bus.goal_x && res_y == bus.goal_y) ? ST_GOAL : ST_ARMED;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x    <= 6'd0;
         pos_y    <= 5'd0;
         cnt      <= '0;
         bump     <= 1'b0;
         pend_vld <= 1'b0;
         pend_dir <= DIR_UP;
         tgt_x    <= 7'd0;
         tgt_y    <= 6'd0;
      end else begin
         bump <= 1'b0;
         if (bus.start) begin
            pos_x    <= bus.start_x;
            pos_y    <= bus.start_y;
            cnt      <= '0;
            pend_vld <= 1'b0;
         end else begin
            case (state)
               ST_ARMED: begin
                  if (bus.draw_done && pend_vld) begin
                     tgt_x <= step_x;
                     tgt_y <= step_y;
                  end else if (!pend_vld && rise_any) begin
                     pend_vld <= 1'b1;
                     pend_dir <= rise_dir;
                  end
               end
               ST_CHECK: begin
                  if (legal) begin
                     pos_x <= res_x;
                     pos_y <= res_y;
                     if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
                  end else begin
                     bump <= 1'b1;
                  end
                  // The serviced request retires here; an edge arriving now becomes the next one.
                  pend_vld <= rise_any;
                  pend_dir <= rise_dir;
               end
               default: pend_vld <= 1'b0;
            endcase
         end
      end
   end

   always_comb begin
      bus.goal     = (state == ST_GOAL);
      bus.state    = state;
      bus.pos_x    = pos_x;
      bus.pos_y    = pos_y;
      bus.bump     = bump;
      bus.move_cnt = cnt;
   end

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios with literal expectations plus randomized play
// compared every cycle against a behavioural grid model.
module tb_player_ctrl;
   import player_pkg::*;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int P_IDLE = 0, P_ARMED = 1, P_CHECK = 2, P_GOAL = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   player_if #(.CNT_W(CW)) bus ();

   player_ctrl #(.ROW(40), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_x, m_y, m_cnt, phase, p_dx, p_dy, t_x, t_y;
   bit         m_bump, p_vld, live;
   logic [3:0] h1, h2, h3;

   function automatic bit allowed(input int x, input int y, input logic [1:0] lvl,
                                  input logic [1199:0] mp);
      int c, r;
      case (lvl)
         2'b01:   begin c = 16; r = 12; end
         2'b10:   begin c = 32; r = 24; end
         2'b11:   begin c = 40; r = 30; end
         default: return 1'b0;
      endcase
      if (x < 0 || y < 0 || x >= c || y >= r) return 1'b0;
      return !mp[1199 - (y * 40 + x)];
   endfunction

   task automatic pick_dir(input logic [3:0] r, output int dx, output int dy);
      dx = 0; dy = 0;
      if (r[3])      dy = -1;
      else if (r[2]) dy = 1;
      else if (r[1]) dx = -1;
      else           dx = 1;
   endtask

   always @(posedge clk) begin
      logic [3:0] r;
      int dx, dy;
      if (rst) begin
         m_x = 0; m_y = 0; m_cnt = 0; m_bump = 0; p_vld = 0; phase = P_IDLE;
         h1 = 0; h2 = 0; h3 = 0; live = 1;
      end else begin
         r = h2 & ~h3;
         pick_dir(r, dx, dy);
         m_bump = 0;
         if (bus.start) begin
            m_x = int'(bus.start_x); m_y = int'(bus.start_y);
            m_cnt = 0; p_vld = 0; phase = P_ARMED;
         end else begin
            case (phase)
               P_ARMED: begin
                  if (bus.draw_done && p_vld) begin
                     t_x = m_x + p_dx; t_y = m_y + p_dy; phase = P_CHECK;
                  end else if (!p_vld && r != 0) begin
                     p_vld = 1; p_dx = dx; p_dy = dy;
                  end
               end
               P_CHECK: begin
                  if (allowed(t_x, t_y, bus.level, bus.map)) begin
                     m_x = t_x; m_y = t_y;
                     if (m_cnt < CMAX) m_cnt++;
                  end else m_bump = 1;
                  p_vld = (r != 0); p_dx = dx; p_dy = dy;
                  phase = (m_x == int'(bus.goal_x) && m_y == int'(bus.goal_y)) ? P_GOAL : P_ARMED;
               end
               P_GOAL:  p_vld = 0;
               default: ;
            endcase
         end
         h3 = h2; h2 = h1; h1 = bus.btn;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("pos_x",    32'(bus.pos_x),    32'(m_x));
         chk("pos_y",    32'(bus.pos_y),    32'(m_y));
         chk("goal",     32'(bus.goal),     32'(phase == P_GOAL));
         chk("bump",     32'(bus.bump),     32'(m_bump));
         chk("move_cnt", 32'(bus.move_cnt), 32'(m_cnt));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int x, input int y);
      bus.start_x = 6'(x); bus.start_y = 5'(y); bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic press(input logic [3:0] m);
      bus.btn = m; tick(2); bus.btn = 4'b0; tick(3);
   endtask

   task automatic frame(output logic b);
      bus.draw_done = 1'b1; tick(1); bus.draw_done = 1'b0; tick(1);
      b = bus.bump;
      tick(1);
   endtask

   task automatic new_map();
      for (int i = 0; i < 1200; i++) bus.map[i] = ($urandom_range(0, 5) == 0);
   endtask

   logic b;

   initial begin
      bus.level = 2'b01; bus.map = '0; bus.btn = 4'b0; bus.draw_done = 1'b0; bus.start = 1'b0;
      bus.start_x = 6'd0; bus.start_y = 5'd0; bus.goal_x = 6'd31; bus.goal_y = 5'd23;
      tick(3);
      rst = 1'b0;
      chk("reset pos_x", 32'(bus.pos_x), 0);
      chk("reset pos_y", 32'(bus.pos_y), 0);
      chk("reset goal",  32'(bus.goal), 0);
      chk("reset cnt",   32'(bus.move_cnt), 0);
      tick(2);

      // basic right step
      do_start(1, 1);
      chk("start pos_x", 32'(bus.pos_x), 1);
      press(4'b0001); frame(b);
      chk("right pos_x", 32'(bus.pos_x), 2);
      chk("right cnt",   32'(bus.move_cnt), 1);

      // wall at (3,1)
      bus.map[1199-43] = 1'b1;
      press(4'b0001); frame(b);
      chk("wall bump",  32'(b), 1);
      chk("wall bump once", 32'(bus.bump), 0);
      chk("wall pos_x", 32'(bus.pos_x), 2);
      chk("wall cnt",   32'(bus.move_cnt), 1);

      // right edge of EZ, then HD
      do_start(15, 5);
      press(4'b0001); frame(b);
      chk("ez edge bump",  32'(b), 1);
      chk("ez edge pos_x", 32'(bus.pos_x), 15);
      bus.level = 2'b11;
      press(4'b0001); frame(b);
      chk("hd pos_x", 32'(bus.pos_x), 16);
      chk("hd cnt",   32'(bus.move_cnt), 1);

      // simultaneous up+left: up wins, left is dropped
      bus.level = 2'b01;
      do_start(2, 2);
      press(4'b1010); frame(b);
      chk("prio pos_x", 32'(bus.pos_x), 2);
      chk("prio pos_y", 32'(bus.pos_y), 1);
      frame(b);
      chk("prio drop pos_x", 32'(bus.pos_x), 2);
      chk("prio drop cnt",   32'(bus.move_cnt), 1);

      // goal reach, freeze, restart
      bus.map = '0; bus.goal_x = 6'd3; bus.goal_y = 5'd1;
      do_start(2, 1);
      press(4'b0001); frame(b);
      chk("goal flag",  32'(bus.goal), 1);
      chk("goal pos_x", 32'(bus.pos_x), 3);
      press(4'b0010); frame(b);
      chk("goal frozen pos_x", 32'(bus.pos_x), 3);
      do_start(2, 1);
      chk("restart goal",  32'(bus.goal), 0);
      chk("restart cnt",   32'(bus.move_cnt), 0);
      chk("restart pos_x", 32'(bus.pos_x), 2);

      // start during CHECK discards the move
      bus.goal_x = 6'd30; bus.goal_y = 5'd20;
      press(4'b0001);
      bus.draw_done = 1'b1; tick(1); bus.draw_done = 1'b0;
      do_start(2, 1);
      chk("abort pos_x", 32'(bus.pos_x), 2);
      chk("abort bump",  32'(bus.bump), 0);
      chk("abort cnt",   32'(bus.move_cnt), 0);
      frame(b);
      chk("abort no move", 32'(bus.pos_x), 2);

      // randomized play
      bus.level = 2'b11; new_map();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 5) == 0) bus.btn = 4'($urandom_range(0, 15));
         bus.draw_done = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 1500) == 0);
         if ($urandom_range(0, 300) == 0) bus.level = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 600) == 0) new_map();
         if ($urandom_range(0, 400) == 0 || c == 0) begin
            bus.start_x = 6'($urandom_range(0, 41)); bus.start_y = 5'($urandom_range(0, 31));
            bus.goal_x  = 6'($urandom_range(0, 39)); bus.goal_y  = 5'($urandom_range(0, 29));
            bus.start = 1'b1;
         end else bus.start = 1'b0;
         tick(1);
      end
      rst = 1'b0; bus.start = 1'b0; bus.draw_done = 1'b0; bus.btn = 4'b0;
      tick(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
